// File: rtl/eth_stats_latched.sv
// Ethernet TX/RX frame and byte statistics with an AXI4-Lite view onto
// shadow copies that are snapshotted together by a latch command.
module eth_stats_latched #(
  parameter int CNT_W    = 64,
  parameter int SAT_MODE = 1,
  parameter int use_time = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] current_time,
  input  logic        time_running,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [11:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [11:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  input  logic        tx_frame_valid,
  input  logic        tx_frame_good,
  input  logic [15:0] tx_frame_bytes,
  input  logic        rx_frame_valid,
  input  logic        rx_frame_good,
  input  logic [15:0] rx_frame_bytes
);

  logic          enable_reg;
  logic          count_ok;
  logic          wr_hs, rd_hs, cfg_wr;
  logic          latch_now, clear_now;
  logic [63:0]   time_shadow_reg;
  logic [6*64-1:0] shadow_flat;
  logic [9:0]    rd_word;
  logic [8:0]    sh_base;
  logic [31:0]   rd_data_next;
  logic          unused_ok;

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                       s_axi_wdata[31:3], s_axi_wstrb[3:1], current_time, time_running};

  assign count_ok  = enable_reg && ((use_time == 0) || time_running);
  assign wr_hs     = s_axi_awvalid && s_axi_awready && s_axi_wvalid && s_axi_wready;
  assign rd_hs     = s_axi_arvalid && s_axi_arready;
  assign cfg_wr    = wr_hs && (s_axi_awaddr[11:2] == 10'd0) && s_axi_wstrb[0];
  assign latch_now = cfg_wr && s_axi_wdata[2];
  assign clear_now = cfg_wr && s_axi_wdata[1];

  // Counter order: TX_BYTES, TX_GOOD, TX_BAD, RX_BYTES, RX_GOOD, RX_BAD.
  for (genvar gi = 0; gi < 6; gi++) begin : g_cnt
    localparam int KIND = gi % 3;
    logic             f_valid, f_good, hit;
    logic [15:0]      f_bytes;
    logic [CNT_W-1:0] amt;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] live_reg, shadow_reg;

    assign f_valid = (gi >= 3) ? rx_frame_valid : tx_frame_valid;
    assign f_good  = (gi >= 3) ? rx_frame_good  : tx_frame_good;
    assign f_bytes = (gi >= 3) ? rx_frame_bytes : tx_frame_bytes;
    assign hit     = count_ok && f_valid && ((KIND == 0) || ((KIND == 1) == f_good));
    assign amt     = (KIND == 0) ? CNT_W'(f_bytes) : CNT_W'(1);
    assign sum     = {1'b0, live_reg} + {1'b0, amt};
    assign shadow_flat[gi*64 +: 64] = 64'(shadow_reg);

    // Shadow samples the value before this cycle's update; clear drops any strobe.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        live_reg   <= '0;
        shadow_reg <= '0;
      end else begin
        if (latch_now)
          shadow_reg <= live_reg;
        if (clear_now)
          live_reg <= '0;
        else if (hit)
          live_reg <= (sum[CNT_W] && (SAT_MODE != 0)) ? '1 : sum[CNT_W-1:0];
      end
    end
  end

  if (use_time != 0) begin : g_time
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        time_shadow_reg <= '0;
      else if (latch_now)
        time_shadow_reg <= current_time;
    end
  end else begin : g_no_time
    assign time_shadow_reg = '0;
  end

  // Words 4..15 map linearly onto the low/high halves of the six shadows.
  assign rd_word = s_axi_araddr[11:2];
  assign sh_base = {rd_word[3:0] - 4'd4, 5'd0};

  always_comb begin
    rd_data_next = '0;
    if (rd_word == 10'd0)
      rd_data_next = {31'd0, enable_reg};
    else if (rd_word == 10'd2)
      rd_data_next = time_shadow_reg[31:0];
    else if (rd_word == 10'd3)
      rd_data_next = time_shadow_reg[63:32];
    else if (rd_word >= 10'd4 && rd_word <= 10'd15)
      rd_data_next = shadow_flat[sh_base +: 32];
  end

  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      enable_reg    <= 1'b0;
    end else begin
      s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      s_axi_wready  <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
      if (wr_hs)
        s_axi_bvalid <= 1'b1;
      else if (s_axi_bready)
        s_axi_bvalid <= 1'b0;
      if (cfg_wr)
        enable_reg <= s_axi_wdata[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
    end else begin
      s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
      if (rd_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data_next;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule
